// File: rtl/terminal_pkg.sv
// Shared constants for the 80x30 character terminal and its 640x480@60 VGA scan.
// The debug writer and the display reader both import this package.
//   - Terminal geometry: 80 columns x 30 rows, cell addresses 0..2399.
//   - VGA timing: horizontal and vertical visible/sync/total counts.
//   - scan_flags_t: active-high region decodes carried down the pipeline.
//   - cell_address(): raster cell index built from shifts (row*80 = row*64 + row*16).
package terminal_pkg;

   localparam logic [11:0] TERMINAL_COLUMNS     = 12'd80;
   localparam logic [11:0] TERMINAL_ROWS        = 12'd30;
   localparam logic [11:0] TERMINAL_ADDRESS_MAX = 12'd2399;

   localparam logic [9:0] H_VISIBLE    = 10'd640;
   localparam logic [9:0] H_SYNC_START = 10'd656;
   localparam logic [9:0] H_SYNC_END   = 10'd752;
   localparam logic [9:0] H_TOTAL      = 10'd800;

   localparam logic [9:0] V_VISIBLE    = 10'd480;
   localparam logic [9:0] V_SYNC_START = 10'd490;
   localparam logic [9:0] V_SYNC_END   = 10'd492;
   localparam logic [9:0] V_TOTAL      = 10'd525;

   // Region decodes, all active high; the pins invert the sync bits.
   typedef struct packed {
      logic visible;
      logic hsync;
      logic vsync;
   } scan_flags_t;

   // Cell index for a character row/column; the x80 multiply is two shifts and an add.
   function automatic logic [11:0] cell_address(input logic [4:0] row, input logic [6:0] column);
      logic [11:0] row_wide;
      row_wide = {7'd0, row};
      return (row_wide << 6) + (row_wide << 4) + {5'd0, column};
   endfunction

endpackage

// File: rtl/vga_timing_generator.sv
// Pixel/line/frame counters and region decode for the VGA scan.
// Ports:
//   clock, reset   pixel clock, asynchronous active-high reset
//   h_count        pixel counter 0..H_TOTAL-1
//   v_position     low 9 bits of the line counter (character row and glyph row)
//   frame_start    high while the counters sit at pixel (0,0)
//   blink_phase    frame counter bit BLINK_BIT
//   flags          combinational visible/hsync/vsync decode of the current counters
// The vertical timing is overridable; the defaults are the 640x480@60 values.
module vga_timing_generator
   import terminal_pkg::*;
#(
   parameter int         BLINK_BIT        = 4,
   parameter logic [9:0] VISIBLE_LINES    = V_VISIBLE,
   parameter logic [9:0] VSYNC_START_LINE = V_SYNC_START,
   parameter logic [9:0] VSYNC_END_LINE   = V_SYNC_END,
   parameter logic [9:0] TOTAL_LINES      = V_TOTAL
) (
   input  logic        clock,
   input  logic        reset,
   output logic [9:0]  h_count,
   output logic [8:0]  v_position,
   output logic        frame_start,
   output logic        blink_phase,
   output scan_flags_t flags
);

   logic [9:0] v_count;
   logic [7:0] frame_count;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         h_count     <= '0;
         v_count     <= '0;
         frame_count <= '0;
      end else if (h_count == H_TOTAL - 10'd1) begin
         h_count <= '0;
         if (v_count == TOTAL_LINES - 10'd1) begin
            v_count     <= '0;
            frame_count <= frame_count + 8'd1;
         end else begin
            v_count <= v_count + 10'd1;
         end
      end else begin
         h_count <= h_count + 10'd1;
      end
   end

   assign v_position    = v_count[8:0];
   assign frame_start   = (h_count == '0) && (v_count == '0);
   assign blink_phase   = frame_count[BLINK_BIT];
   assign flags.visible = (h_count < H_VISIBLE) && (v_count < VISIBLE_LINES);
   assign flags.hsync   = (h_count >= H_SYNC_START) && (h_count < H_SYNC_END);
   assign flags.vsync   = (v_count >= VSYNC_START_LINE) && (v_count < VSYNC_END_LINE);

endmodule

// File: rtl/terminal_display_reader.sv
// Read side of the 80x30 terminal buffer: raster scan -> character fetch -> glyph
// fetch -> RGB444 pixel with a blinking inverse-video cursor cell.
// Ports:
//   clock, reset                    25 MHz pixel clock, asynchronous active-high reset
//   cursorAddress                   cursor cell; >= 2400 disables the cursor
//   terminalReadAddress / Data      terminal RAM read port (data valid one clock later)
//   fontAddress / fontData          font ROM {char, glyph row} -> 8-pixel row, bit 7 leftmost
//   vgaRed/Green/Blue               pixel colour, black outside the visible area
//   vgaHsync / vgaVsync             active-low syncs
// Every output reflects the counters from exactly three clocks earlier.
module terminal_display_reader
   import terminal_pkg::*;
#(
   parameter logic [11:0] FOREGROUND       = 12'hFFF,
   parameter logic [11:0] BACKGROUND       = 12'h000,
   parameter int          BLINK_BIT        = 4,
   parameter logic [9:0]  VISIBLE_LINES    = V_VISIBLE,
   parameter logic [9:0]  VSYNC_START_LINE = V_SYNC_START,
   parameter logic [9:0]  VSYNC_END_LINE   = V_SYNC_END,
   parameter logic [9:0]  TOTAL_LINES      = V_TOTAL
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] cursorAddress,
   output logic [11:0] terminalReadAddress,
   input  logic [7:0]  terminalReadData,
   output logic [11:0] fontAddress,
   input  logic [7:0]  fontData,
   output logic [3:0]  vgaRed,
   output logic [3:0]  vgaGreen,
   output logic [3:0]  vgaBlue,
   output logic        vgaHsync,
   output logic        vgaVsync
);

   logic [9:0]  h_count;
   logic [8:0]  v_position;
   logic        frame_start;
   logic        blink_phase;
   scan_flags_t flags;

   vga_timing_generator #(
      .BLINK_BIT        (BLINK_BIT),
      .VISIBLE_LINES    (VISIBLE_LINES),
      .VSYNC_START_LINE (VSYNC_START_LINE),
      .VSYNC_END_LINE   (VSYNC_END_LINE),
      .TOTAL_LINES      (TOTAL_LINES)
   ) timing (
      .clock       (clock),
      .reset       (reset),
      .h_count     (h_count),
      .v_position  (v_position),
      .frame_start (frame_start),
      .blink_phase (blink_phase),
      .flags       (flags)
   );

   logic [11:0] cursor_latched;
   logic [11:0] cursor_current;
   logic        cursor_enabled;
   logic [11:0] scan_address;

   scan_flags_t flags_d1, flags_d2;
   logic [3:0]  glyph_row_d1;
   logic [2:0]  pixel_column_d1, pixel_column_d2;
   logic        cursor_hit_d1, cursor_hit_d2;
   logic        pixel_bit;

   // At pixel (0,0) the live input is the value being latched for this frame, so the
   // whole frame (including its first cell) uses one cursor position.
   assign cursor_current = frame_start ? cursorAddress : cursor_latched;
   assign cursor_enabled = blink_phase && (cursor_current <= TERMINAL_ADDRESS_MAX);
   assign scan_address   = flags.visible ? cell_address(v_position[8:4], h_count[9:3]) : '0;
   assign pixel_bit      = fontData[3'd7 - pixel_column_d2] ^ cursor_hit_d2;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cursor_latched                   <= 12'hFFF;
         terminalReadAddress              <= '0;
         fontAddress                      <= '0;
         flags_d1                         <= '0;
         flags_d2                         <= '0;
         glyph_row_d1                     <= '0;
         pixel_column_d1                  <= '0;
         pixel_column_d2                  <= '0;
         cursor_hit_d1                    <= 1'b0;
         cursor_hit_d2                    <= 1'b0;
         {vgaRed, vgaGreen, vgaBlue}      <= '0;
         vgaHsync                         <= 1'b1;
         vgaVsync                         <= 1'b1;
      end else begin
         if (frame_start) begin
            cursor_latched <= cursorAddress;
         end

         // Stage 0: character fetch address.
         terminalReadAddress <= scan_address;
         flags_d1            <= flags;
         glyph_row_d1        <= v_position[3:0];
         pixel_column_d1     <= h_count[2:0];
         cursor_hit_d1       <= flags.visible && cursor_enabled && (scan_address == cursor_current);

         // Stage 1: glyph row fetch address; held at 0 through blanking.
         fontAddress     <= flags_d1.visible ? {terminalReadData, glyph_row_d1} : '0;
         flags_d2        <= flags_d1;
         pixel_column_d2 <= pixel_column_d1;
         cursor_hit_d2   <= cursor_hit_d1;

         // Stages 2/3: pick the glyph bit and register the pins.
         if (flags_d2.visible) begin
            {vgaRed, vgaGreen, vgaBlue} <= pixel_bit ? FOREGROUND : BACKGROUND;
         end else begin
            {vgaRed, vgaGreen, vgaBlue} <= '0;
         end
         vgaHsync <= ~flags_d2.hsync;
         vgaVsync <= ~flags_d2.vsync;
      end
   end

endmodule
